// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg
//   Shared types and default sizing for the pulse stretcher.
//   ps_state_t : FSM state encoding (IDLE, HIGH, GAP).
//   PS_HIGH_CYCLES / PS_GAP_CYCLES : default pulse width and minimum gap.
//   ps_cnt_w() : down-counter width that holds max(high, gap).
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } ps_state_t;

   localparam int unsigned PS_HIGH_CYCLES = 16;
   localparam int unsigned PS_GAP_CYCLES  = 4;

   function automatic int unsigned ps_cnt_w(input int unsigned hi_cycles,
                                            input int unsigned gap_cycles);
      int unsigned m;
      m = (hi_cycles > gap_cycles) ? hi_cycles : gap_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pulse_stretch_edge_detect.sv
// edge_detect
//   Single-register edge detector on a clk-synchronous level.
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset; prev <= RESET_VAL
//     data_in  : level to watch
//     detected : combinational edge flag (rising, or falling if FALLING=1)
//   RESET_VAL=1 with rising detection suppresses an event for a level that
//   is already high when reset releases.
module edge_detect #(
   parameter logic RESET_VAL = 1'b1,
   parameter logic FALLING   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic data_in,
   output logic detected
);

   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= RESET_VAL;
      end else begin
         prev <= data_in;
      end
   end

   assign detected = FALLING ? (~data_in & prev) : (data_in & ~prev);

endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch
//   Stretches short event pulses into HIGH_CYCLES-wide pulses separated by
//   at least GAP_CYCLES low cycles. One event arriving during a pulse is
//   queued; further events are dropped and flagged.
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset, truncates any pulse
//     data_in  : event request, a sampled 0->1 transition is one event
//     data_out : stretched pulse (decoded from state)
//     busy     : high whenever not IDLE
//     missed   : one-cycle strobe, an event was dropped
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned HIGH_CYCLES = PS_HIGH_CYCLES,
   parameter int unsigned GAP_CYCLES  = PS_GAP_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic data_in,
   output logic data_out,
   output logic busy,
   output logic missed
);

   localparam int unsigned CNT_W = ps_cnt_w(HIGH_CYCLES, GAP_CYCLES);
   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   ps_state_t        state;
   logic [CNT_W-1:0] count;
   logic             pending;
   logic             hit;

   edge_detect #(
      .RESET_VAL (1'b1),
      .FALLING   (1'b0)
   ) u_edge (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .detected (hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         pending <= 1'b0;
         missed  <= 1'b0;
      end else begin
         missed <= 1'b0;
         case (state)
            IDLE: begin
               if (hit) begin
                  state <= HIGH;
                  count <= HIGH_LOAD;
               end
            end
            HIGH: begin
               if (count == '0) begin
                  state <= GAP;
                  count <= GAP_LOAD;
               end else begin
                  count <= count - CNT_ONE;
               end
               if (hit) begin
                  if (pending) missed  <= 1'b1;
                  else         pending <= 1'b1;
               end
            end
            GAP: begin
               if (count == '0) begin
                  if (pending || hit) begin
                     state   <= HIGH;
                     count   <= HIGH_LOAD;
                     // With a queued event, a coincident new edge takes
                     // over the queue slot instead of being dropped.
                     pending <= pending & hit;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  count <= count - CNT_ONE;
                  if (hit) begin
                     if (pending) missed  <= 1'b1;
                     else         pending <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               count   <= '0;
               pending <= 1'b0;
            end
         endcase
      end
   end

   assign data_out = (state == HIGH);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch
//   Directed scenarios for pulse_stretch with HIGH_CYCLES=16, GAP_CYCLES=4.
//   Each scenario applies a per-edge stimulus vector; trace bit c holds the
//   output value seen during cycle c (i.e. just after edge c-1).
module tb_pulse_stretch;

   logic clk;
   logic rst;
   logic data_in;
   logic data_out;
   logic busy;
   logic missed;

   int tests_run;
   int tests_failed;

   logic stim_din [0:127];
   logic stim_rst [0:127];
   logic [127:0] tr_do;
   logic [127:0] tr_busy;
   logic [127:0] tr_miss;

   pulse_stretch #(
      .HIGH_CYCLES (16),
      .GAP_CYCLES  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy),
      .missed   (missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] rng(input int lo, input int hi);
      logic [127:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic clear_stim();
      for (int i = 0; i < 128; i++) begin
         stim_din[i] = 1'b0;
         stim_rst[i] = 1'b0;
      end
   endtask

   // Reset for two edges, then apply stim for edges 0..n-1.
   task automatic run_scenario(input int n);
      tr_do   = '0;
      tr_busy = '0;
      tr_miss = '0;
      rst     = 1'b1;
      data_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         data_in = stim_din[i];
         rst     = stim_rst[i];
         @(negedge clk);
         tr_do[i+1]   = data_out;
         tr_busy[i+1] = busy;
         tr_miss[i+1] = missed;
      end
      rst     = 1'b0;
      data_in = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      data_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (data_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_data_out got %b expected 0", data_out);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy got %b expected 0", busy);
      end
      tests_run++;
      if (missed !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_missed got %b expected 0", missed);
      end
   endtask

   task automatic test_single_pulse();
      clear_stim();
      stim_din[10] = 1'b1;
      run_scenario(40);
      tests_run++;
      if (tr_do !== rng(11, 26)) begin
         tests_failed++;
         $display("FAIL single_data_out got %h expected %h", tr_do, rng(11, 26));
      end
      tests_run++;
      if (tr_busy !== rng(11, 30)) begin
         tests_failed++;
         $display("FAIL single_busy got %h expected %h", tr_busy, rng(11, 30));
      end
      tests_run++;
      if (tr_miss !== 128'd0) begin
         tests_failed++;
         $display("FAIL single_missed got %h expected 0", tr_miss);
      end
   endtask

   task automatic test_held_level();
      clear_stim();
      for (int i = 10; i < 110; i++) stim_din[i] = 1'b1;
      run_scenario(120);
      tests_run++;
      if (tr_do !== rng(11, 26)) begin
         tests_failed++;
         $display("FAIL held_data_out got %h expected %h", tr_do, rng(11, 26));
      end
      tests_run++;
      if (tr_busy !== rng(11, 30)) begin
         tests_failed++;
         $display("FAIL held_busy got %h expected %h", tr_busy, rng(11, 30));
      end
      tests_run++;
      if (tr_miss !== 128'd0) begin
         tests_failed++;
         $display("FAIL held_missed got %h expected 0", tr_miss);
      end
   endtask

   task automatic test_queued();
      clear_stim();
      stim_din[10] = 1'b1;
      stim_din[15] = 1'b1;
      run_scenario(60);
      tests_run++;
      if (tr_do !== (rng(11, 26) | rng(31, 46))) begin
         tests_failed++;
         $display("FAIL queued_data_out got %h expected %h", tr_do, rng(11, 26) | rng(31, 46));
      end
      tests_run++;
      if (tr_busy !== rng(11, 50)) begin
         tests_failed++;
         $display("FAIL queued_busy got %h expected %h", tr_busy, rng(11, 50));
      end
      tests_run++;
      if (tr_miss !== 128'd0) begin
         tests_failed++;
         $display("FAIL queued_missed got %h expected 0", tr_miss);
      end
   endtask

   task automatic test_dropped();
      clear_stim();
      stim_din[12] = 1'b1;
      stim_din[15] = 1'b1;
      stim_din[18] = 1'b1;
      run_scenario(70);
      tests_run++;
      if (tr_do !== (rng(13, 28) | rng(33, 48))) begin
         tests_failed++;
         $display("FAIL dropped_data_out got %h expected %h", tr_do, rng(13, 28) | rng(33, 48));
      end
      tests_run++;
      if (tr_busy !== rng(13, 52)) begin
         tests_failed++;
         $display("FAIL dropped_busy got %h expected %h", tr_busy, rng(13, 52));
      end
      tests_run++;
      if (tr_miss !== rng(19, 19)) begin
         tests_failed++;
         $display("FAIL dropped_missed got %h expected %h", tr_miss, rng(19, 19));
      end
   endtask

   task automatic test_back_to_back();
      clear_stim();
      stim_din[10] = 1'b1;
      stim_din[15] = 1'b1;
      stim_din[30] = 1'b1;
      run_scenario(90);
      tests_run++;
      if (tr_do !== (rng(11, 26) | rng(31, 46) | rng(51, 66))) begin
         tests_failed++;
         $display("FAIL b2b_data_out got %h expected %h", tr_do,
                  rng(11, 26) | rng(31, 46) | rng(51, 66));
      end
      tests_run++;
      if (tr_busy !== rng(11, 70)) begin
         tests_failed++;
         $display("FAIL b2b_busy got %h expected %h", tr_busy, rng(11, 70));
      end
      tests_run++;
      if (tr_miss !== 128'd0) begin
         tests_failed++;
         $display("FAIL b2b_missed got %h expected 0", tr_miss);
      end
   endtask

   task automatic test_mid_reset();
      clear_stim();
      for (int i = 10; i < 60; i++) stim_din[i] = 1'b1;
      stim_rst[20] = 1'b1;
      stim_rst[21] = 1'b1;
      run_scenario(60);
      tests_run++;
      if (tr_do !== rng(11, 20)) begin
         tests_failed++;
         $display("FAIL midrst_data_out got %h expected %h", tr_do, rng(11, 20));
      end
      tests_run++;
      if (tr_busy !== rng(11, 20)) begin
         tests_failed++;
         $display("FAIL midrst_busy got %h expected %h", tr_busy, rng(11, 20));
      end
      tests_run++;
      if (tr_miss !== 128'd0) begin
         tests_failed++;
         $display("FAIL midrst_missed got %h expected 0", tr_miss);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      data_in      = 1'b0;
      test_reset();
      test_single_pulse();
      test_held_level();
      test_queued();
      test_dropped();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
